// File: rtl/memory_uart_dump.sv
// Streams a snapshot of the emulated DS2431 memory and option bytes out as 8N1 UART frames.
// Optional trailing checksum byte is built when MEMORY_UART_DUMP_CHECKSUM_EN is defined.
module memory_uart_dump #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [1023:0] memoryDat,
  input  logic [63:0]   optionBytes,
  input  logic          memoryUpdated,
  output logic          tx,
  output logic          busy
);

  localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  PAYLOAD_END = 8'd138;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
  localparam logic [7:0]  LAST_IDX = 8'd138;
`else
  localparam logic [7:0]  LAST_IDX = 8'd137;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     byte_q, byte_d;
  logic           pending_q, pending_d;
  logic           prev_q;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic [1087:0]  snap_q;
  logic           snap_en;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
  logic [7:0]     cksum_q, cksum_d;
`endif

  logic           req;
  logic           wrap;
  logic           is_payload;
  logic [7:0]     pay_idx;
  logic [10:0]    pay_base;
  logic [7:0]     cur_byte;

  assign req        = memoryUpdated & ~prev_q;
  assign wrap       = (timer_q == TIMER_MAX);
  assign is_payload = (byte_q >= 8'd2) && (byte_q < PAYLOAD_END);
  assign pay_idx    = byte_q - 8'd2;
  assign pay_base   = {pay_idx, 3'b000};
  assign tx         = tx_q;
  assign busy       = busy_q;

  // Byte currently on the wire, selected from the frame position.
  always_comb begin
    cur_byte = 8'h00;
    if (byte_q == 8'd0) begin
      cur_byte = 8'h55;
    end else if (byte_q == 8'd1) begin
      cur_byte = 8'hAA;
    end else if (is_payload) begin
      cur_byte = snap_q[pay_base +: 8];
    end
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
    else begin
      cur_byte = cksum_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pending_d = pending_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    snap_en   = 1'b0;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
    cksum_d   = cksum_q;
`endif

    if (state_q != S_IDLE) begin
      timer_d = wrap ? 16'd0 : timer_q + 16'd1;
      if (req) begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        timer_d = 16'd0;
        if (req) begin
          state_d = S_START;
          byte_d  = 8'd0;
          snap_en = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
          cksum_d = 8'd0;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
          if (is_payload) begin
            cksum_d = cksum_q + cur_byte;
          end
`endif
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (wrap) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (wrap) begin
          if (byte_q != LAST_IDX) begin
            state_d = S_START;
            byte_d  = byte_q + 8'd1;
            tx_d    = 1'b0;
          end else if (pending_q || req) begin
            // Merged request restarts back-to-back with a fresh snapshot.
            state_d   = S_START;
            pending_d = 1'b0;
            snap_en   = 1'b1;
            byte_d    = 8'd0;
            tx_d      = 1'b0;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
            cksum_d   = 8'd0;
`endif
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      timer_q   <= 16'd0;
      bit_q     <= 3'd0;
      byte_q    <= 8'd0;
      pending_q <= 1'b0;
      prev_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
      cksum_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pending_q <= pending_d;
      prev_q    <= memoryUpdated;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  // Snapshot is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      snap_q <= {optionBytes, memoryDat};
    end
  end

endmodule

// File: tb/tb_memory_uart_dump.sv
// Testbench for memory_uart_dump: decodes the UART line and compares against a frame model.
module tb_memory_uart_dump;

  localparam int CPB = 4;
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
  localparam int NB = 139;
`else
  localparam int NB = 138;
`endif
  localparam int DUMP = 10 * CPB * NB;

  logic          clk;
  logic          nRst;
  logic [1023:0] memoryDat;
  logic [63:0]   optionBytes;
  logic          memoryUpdated;
  logic          tx;
  logic          busy;

  memory_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .nRst(nRst),
    .memoryDat(memoryDat),
    .optionBytes(optionBytes),
    .memoryUpdated(memoryUpdated),
    .tx(tx),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int frame_err = 0;
  int busy_cyc = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_exp[$];
  logic [7:0] mem_b[128];
  logic [7:0] opt_b[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
    end
  end

  // UART receiver: samples each bit near its middle.
  initial begin
    bit act;
    int cnt;
    logic [7:0] sh;
    act = 1'b0;
    cnt = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (nRst !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == 2) begin
          if (tx !== 1'b0) frame_err++;
        end else if (cnt >= 6 && cnt <= 34 && ((cnt - 2) % CPB) == 0) begin
          sh[(cnt - 6) / CPB] = tx;
        end else if (cnt == 38) begin
          if (tx !== 1'b1) frame_err++;
          q_rx.push_back(sh);
          act = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < 128; k++) memoryDat[8*k +: 8] = mem_b[k];
    for (int j = 0; j < 8; j++) optionBytes[8*j +: 8] = opt_b[j];
  endtask

  task automatic rand_data();
    for (int k = 0; k < 128; k++) mem_b[k] = 8'($urandom);
    for (int j = 0; j < 8; j++) opt_b[j] = 8'($urandom);
    drive_data();
  endtask

  task automatic push_dump();
    int sum;
    sum = 0;
    q_exp.push_back(8'h55);
    q_exp.push_back(8'hAA);
    for (int k = 0; k < 128; k++) begin
      q_exp.push_back(mem_b[k]);
      sum += mem_b[k];
    end
    for (int j = 0; j < 8; j++) begin
      q_exp.push_back(opt_b[j]);
      sum += opt_b[j];
    end
`ifdef MEMORY_UART_DUMP_CHECKSUM_EN
    q_exp.push_back(8'(sum % 256));
`endif
  endtask

  task automatic pulse();
    @(posedge clk);
    #1 memoryUpdated = 1'b1;
    @(posedge clk);
    #1 memoryUpdated = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 20000 && q_rx.size() < n; i++) @(negedge clk);
    chk("wait_rx", 32'(q_rx.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40000 && busy !== 1'b0; i++) @(negedge clk);
    chk("wait_idle", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_dump(input string tag, input int exp_busy);
    chk({tag, "_len"}, 32'(q_rx.size()), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size(); i++) begin
      if (i < q_rx.size()) chk($sformatf("%s_b%0d", tag, i), 32'(q_rx[i]), 32'(q_exp[i]));
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    chk({tag, "_framing"}, 32'(frame_err), 32'd0);
    q_rx.delete();
    q_exp.delete();
    frame_err = 0;
    busy_cyc = 0;
  endtask

  initial begin
    int bad;
    nRst = 1'b0;
    memoryUpdated = 1'b0;
    memoryDat = '0;
    optionBytes = '0;

    // Reset and idle line
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    nRst = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_1000", 32'(bad), 32'd0);
    chk("idle_no_bytes", 32'(q_rx.size()), 32'd0);
    busy_cyc = 0;

    // Basic dump with ramp data
    for (int k = 0; k < 128; k++) mem_b[k] = 8'(k);
    for (int j = 0; j < 8; j++) opt_b[j] = 8'(8'hF0 + j);
    drive_data();
    push_dump();
    pulse();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_tx", 32'(tx), 32'd0);
    wait_idle();
    check_dump("basic", DUMP);

    // Level held high gives exactly one dump
    rand_data();
    push_dump();
    @(posedge clk);
    #1 memoryUpdated = 1'b1;
    repeat (20000) @(posedge clk);
    #1 memoryUpdated = 1'b0;
    wait_idle();
    check_dump("level", DUMP);

    // Two requests during a dump merge into one back-to-back dump
    rand_data();
    push_dump();
    pulse();
    wait_rx(10);
    pulse();
    mem_b[0] = 8'h5A;
    drive_data();
    wait_rx(50);
    pulse();
    push_dump();
    wait_idle();
    check_dump("merge", 2 * DUMP);

    // Memory changes mid-dump are not transmitted
    rand_data();
    push_dump();
    pulse();
    wait_rx(30);
    for (int k = 0; k < 128; k++) mem_b[k] = 8'hFF;
    drive_data();
    wait_idle();
    check_dump("isolate", DUMP);

    // Reset during DATA bit 3 of byte 20, then a fresh dump
    rand_data();
    pulse();
    wait_rx(20);
    repeat (19) @(posedge clk);
    #1 nRst = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1 nRst = 1'b1;
    q_rx.delete();
    frame_err = 0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_idle", 32'(bad), 32'd0);
    busy_cyc = 0;
    rand_data();
    push_dump();
    pulse();
    chk("post_rst_lat_busy", 32'(busy), 32'd1);
    wait_idle();
    check_dump("after_reset", DUMP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
